// File: rtl/countdown_timer.sv
// MM:SS countdown timer with button set, start/pause and a timed alarm.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to reload the preset on expiry instead.
module countdown_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_MIN   = 99,
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic       tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
    localparam logic [7:0]    MAX_BCD    = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [AW-1:0] alarm_cnt;
    logic          start_q, min_q, sec_q;
    logic          start_ev, min_ev, sec_ev;
    logic          pre_wrap, dec_zero;
    logic [7:0]    dec_min, dec_sec;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [7:0]    preset_min, preset_sec;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = v + 8'd1;
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
        else                r = v - 8'd1;
        return r;
    endfunction

    assign start_ev = btn_start & ~start_q;
    assign min_ev   = btn_min & ~min_q;
    assign sec_ev   = btn_sec & ~sec_q;
    assign pre_wrap = (pre == PRE_LAST);

    // one-second decrement with borrow from minutes
    always_comb begin
        dec_min = min_bcd;
        dec_sec = bcd_dec(sec_bcd);
        if (sec_bcd == 8'h00) begin
            dec_min = bcd_dec(min_bcd);
            dec_sec = 8'h59;
        end
    end

    assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SET;
            pre       <= '0;
            alarm_cnt <= '0;
            start_q   <= 1'b0;
            min_q     <= 1'b0;
            sec_q     <= 1'b0;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            running   <= 1'b0;
            alarm     <= 1'b0;
            tick      <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            preset_min <= 8'h00;
            preset_sec <= 8'h00;
`endif
        end else begin
            start_q <= btn_start;
            min_q   <= btn_min;
            sec_q   <= btn_sec;
            tick    <= 1'b0;
            if (clr) begin
                state     <= S_SET;
                pre       <= '0;
                alarm_cnt <= '0;
                min_bcd   <= 8'h00;
                sec_bcd   <= 8'h00;
                running   <= 1'b0;
                alarm     <= 1'b0;
            end else begin
                unique case (state)
                    S_SET: begin
                        if (start_ev && ((min_bcd | sec_bcd) != 8'h00)) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                            pre     <= '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            preset_min <= min_bcd;
                            preset_sec <= sec_bcd;
`endif
                        end else begin
                            if (min_ev)
                                min_bcd <= (min_bcd == MAX_BCD) ? 8'h00 : bcd_inc(min_bcd);
                            if (sec_ev)
                                sec_bcd <= (sec_bcd == 8'h59) ? 8'h00 : bcd_inc(sec_bcd);
                        end
                    end
                    S_RUN: begin
                        alarm <= 1'b0;
                        if (start_ev) begin
                            state   <= S_PAUSE;
                            running <= 1'b0;
                        end else if (pre_wrap) begin
                            pre  <= '0;
                            tick <= 1'b1;
                            if (dec_zero) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                                min_bcd <= preset_min;
                                sec_bcd <= preset_sec;
                                alarm   <= 1'b1;
`else
                                min_bcd   <= 8'h00;
                                sec_bcd   <= 8'h00;
                                state     <= S_ALARM;
                                running   <= 1'b0;
                                alarm     <= 1'b1;
                                alarm_cnt <= '0;
`endif
                            end else begin
                                min_bcd <= dec_min;
                                sec_bcd <= dec_sec;
                            end
                        end else begin
                            pre <= pre + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (start_ev) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_ALARM: begin
                        if (start_ev) begin
                            state     <= S_SET;
                            alarm     <= 1'b0;
                            pre       <= '0;
                            alarm_cnt <= '0;
                        end else if (pre_wrap) begin
                            pre <= '0;
                            if (alarm_cnt == ALARM_LAST) begin
                                state     <= S_SET;
                                alarm     <= 1'b0;
                                alarm_cnt <= '0;
                            end else begin
                                alarm_cnt <= alarm_cnt + AW'(1);
                            end
                        end else begin
                            pre <= pre + PW'(1);
                        end
                    end
                    default: state <= S_SET;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, alarm, tick;

    countdown_timer #(
        .TICK_DIV (4),
        .MAX_MIN  (99),
        .ALARM_SEC(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .btn_start(btn_start),
        .btn_min  (btn_min),
        .btn_sec  (btn_sec),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .running  (running),
        .alarm    (alarm),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       alm;
        logic       tck;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mi;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].cyc <= cyc) begin
                n_checks++;
                if (sb[mi].cyc != cyc ||
                    {min_bcd, sec_bcd, running, alarm, tick} !==
                    {sb[mi].mn, sb[mi].sc, sb[mi].run, sb[mi].alm, sb[mi].tck}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d/%0d: got %h:%h run=%b alm=%b tick=%b, want %h:%h run=%b alm=%b tick=%b",
                             sb[mi].name, cyc, sb[mi].cyc, min_bcd, sec_bcd, running, alarm, tick,
                             sb[mi].mn, sb[mi].sc, sb[mi].run, sb[mi].alm, sb[mi].tck);
                end
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    function automatic logic [7:0] tobcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic expect_at(input int dly, input string nm, input logic [7:0] mn,
                             input logic [7:0] sc, input logic run, input logic alm,
                             input logic tck);
        exp_t e;
        e.cyc  = cyc + dly;
        e.name = nm;
        e.mn   = mn;
        e.sc   = sc;
        e.run  = run;
        e.alm  = alm;
        e.tck  = tck;
        sb.push_back(e);
    endtask

    // which: 0 start, 1 min, 2 sec; one cycle high then one cycle low
    task automatic press(input int which, input string nm, input logic [7:0] mn,
                         input logic [7:0] sc, input bit chk);
        btn_start = (which == 0);
        btn_min   = (which == 1);
        btn_sec   = (which == 2);
        if (chk) expect_at(1, nm, mn, sc, 1'b0, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        btn_min   = 1'b0;
        btn_sec   = 1'b0;
        clk1();
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        expect_at(1, nm, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        clr = 1'b0;
        clk1();
    endtask

    initial begin
        int m;
        logic [7:0] emn, esc;
        logic       erun, ealm, etck;

        repeat (2) clk1();
        expect_at(1, "reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        reset = 1'b0;
        clk1();

        // seconds then minutes, minute wrap at MAX_MIN
        press(2, "sec1", 8'h00, 8'h01, 1);
        press(2, "sec2", 8'h00, 8'h02, 1);
        press(2, "sec3", 8'h00, 8'h03, 1);
        press(1, "min1", 8'h01, 8'h03, 1);
        m = 1;
        for (int i = 1; i <= 99; i++) begin
            m = (m + 1) % 100;
            press(1, "min_wrap", tobcd(m), 8'h03, (i >= 97));
        end
        do_clr("clr_set");

        btn_min = 1'b1;
        btn_sec = 1'b1;
        expect_at(1, "both_inc", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        clk1();
        btn_min = 1'b0;
        btn_sec = 1'b0;
        clk1();
        do_clr("clr_both");

        press(0, "start_zero", 8'h00, 8'h00, 1);
        btn_sec = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_at(1, "sec_held", 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
            clk1();
        end
        btn_sec = 1'b0;
        clk1();
        do_clr("clr_held");

        // 00:02 run to expiry
        press(2, "set_0001", 8'h00, 8'h01, 1);
        press(2, "set_0002", 8'h00, 8'h02, 1);
        btn_start = 1'b1;
        expect_at(1, "start_0002", 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            emn  = 8'h00;
            etck = (k % 4 == 0);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            esc  = ((k / 4) % 2 == 1) ? 8'h01 : 8'h02;
            erun = 1'b1;
            ealm = (k == 8) || (k == 16);
`else
            etck = (k == 4) || (k == 8);
            if (k < 4) begin
                esc = 8'h02; erun = 1'b1; ealm = 1'b0;
            end else if (k < 8) begin
                esc = 8'h01; erun = 1'b1; ealm = 1'b0;
            end else begin
                esc = 8'h00; erun = 1'b0; ealm = (k < 16);
            end
`endif
            expect_at(k, "expiry_seq", emn, esc, erun, ealm, etck);
        end
        repeat (16) clk1();
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        press(2, "back_in_set", 8'h00, 8'h01, 1);
`endif
        do_clr("clr_expiry");

        // pause and resume from held prescaler
        press(1, "set_0100", 8'h01, 8'h00, 1);
        btn_start = 1'b1;
        expect_at(1, "start_0100", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k < 4) expect_at(k, "run_0100", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
            else       expect_at(k, "run_0059", 8'h00, 8'h59, 1'b1, 1'b0, (k == 4));
        end
        repeat (6) clk1();
        btn_start = 1'b1;
        expect_at(1, "pause", 8'h00, 8'h59, 1'b0, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            btn_min = (i == 5);
            expect_at(1, "paused", 8'h00, 8'h59, 1'b0, 1'b0, 1'b0);
            clk1();
        end
        btn_min = 1'b0;
        btn_start = 1'b1;
        expect_at(1, "resume", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
        expect_at(2, "resume_pre", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
        expect_at(3, "resume_tick", 8'h00, 8'h58, 1'b1, 1'b0, 1'b1);
        clk1();
        btn_start = 1'b0;
        repeat (2) clk1();
        do_clr("clr_pause");

        // clr overrides a start event mid-run
        for (int i = 1; i <= 30; i++)
            press(2, "set_0030", 8'h00, tobcd(i), (i == 30));
        btn_start = 1'b1;
        expect_at(1, "start_0030", 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        clk1();
        clr = 1'b1;
        btn_start = 1'b1;
        expect_at(1, "clr_over_start", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        clr = 1'b0;
        btn_start = 1'b0;
        expect_at(1, "after_clr", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        press(2, "set_after_clr", 8'h00, 8'h01, 1);

        btn_start = 1'b1;
        expect_at(1, "start_0001", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        expect_at(4, "alarm_on", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        repeat (5) clk1();
        btn_start = 1'b1;
        expect_at(1, "alarm_ack", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        clk1();
        press(2, "set_again", 8'h00, 8'h01, 1);
        btn_start = 1'b1;
        expect_at(1, "start_again", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        clk1();
        btn_start = 1'b0;
        expect_at(4, "alarm_on2", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
`else
        expect_at(4, "reload_0001", 8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
`endif
        repeat (6) clk1();
        reset = 1'b1;
        btn_sec = 1'b1;
        expect_at(1, "reset_mid", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();
        reset = 1'b0;
        btn_sec = 1'b0;
        expect_at(1, "post_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk1();

        repeat (3) clk1();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
